// File: rtl/dp_mem_responder.sv
// Datapath-side memory responder: arbitrates fetch/data requests onto
// one RAM port and serves repeated fetches from a one-entry buffer.
module dp_mem_responder #(
  parameter int RAM_TIMEOUT = 255,
  parameter bit IBUF_EN     = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    IREQ,
    DREQ,
    ERR
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } dreq_t;

  localparam logic [1:0]  RS_ACCESS = 2'd2;
  localparam logic [1:0]  RS_ERROR  = 2'd3;
  localparam logic [31:0] TMO       = 32'(RAM_TIMEOUT);

  state_t      state, state_n;
  dreq_t       dreq_q;
  logic [31:0] iaddr_q;
  logic [31:0] tag_q;
  logic [31:0] bdata_q;
  logic        bvld_q;
  logic [31:0] tcnt_q;

  logic        bhit;
  logic        binval;
  logic        tmo;
  logic        iacc;
  logic        dacc;
  logic        ifill;

  // Buffer lookup; a store hitting the tag kills the entry this cycle.
  always_comb begin
    binval = 1'b0;
    bhit   = 1'b0;
    tmo    = 1'b0;
    binval = (state == IDLE) && dmemWEN &&
             bvld_q && (dmemaddr == tag_q);
    bhit   = IBUF_EN && bvld_q && imemREN &&
             !halt && (imemaddr == tag_q) &&
             (state != ERR) && !binval;
    tmo    = (TMO != 32'd0) &&
             (tcnt_q == TMO - 32'd1);
  end

  // Next-state logic and all datapath/RAM-side outputs.
  always_comb begin
    state_n  = state;
    ihit     = 1'b0;
    imemload = '0;
    dhit     = 1'b0;
    dmemload = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;
    iacc     = 1'b0;
    dacc     = 1'b0;
    ifill    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          dacc    = 1'b1;
          state_n = DREQ;
        end else if (imemREN && !halt && !bhit) begin
          iacc    = 1'b1;
          state_n = IREQ;
        end
      end
      IREQ: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_q;
        unique case (1'b1)
          ramstate == RS_ACCESS: begin
            ihit     = 1'b1;
            imemload = ramload;
            ifill    = 1'b1;
            state_n  = IDLE;
          end
          ramstate == RS_ERROR: state_n = ERR;
          tmo:                  state_n = ERR;
          default:              state_n = IREQ;
        endcase
      end
      DREQ: begin
        ramREN   = !dreq_q.wr;
        ramWEN   = dreq_q.wr;
        ramaddr  = dreq_q.addr;
        ramstore = dreq_q.wr ? dreq_q.data : '0;
        unique case (1'b1)
          ramstate == RS_ACCESS: begin
            dhit     = 1'b1;
            dmemload = dreq_q.wr ? '0 : ramload;
            state_n  = IDLE;
          end
          ramstate == RS_ERROR: state_n = ERR;
          tmo:                  state_n = ERR;
          default:              state_n = DREQ;
        endcase
      end
      ERR: err = 1'b1;
      default: state_n = ERR;
    endcase
    if (bhit && !ihit) begin
      ihit     = 1'b1;
      imemload = bdata_q;
    end
  end

  // State, request latches, timeout counter and buffer entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dreq_q  <= '0;
      iaddr_q <= '0;
      tag_q   <= '0;
      bdata_q <= '0;
      bvld_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state <= state_n;
      if (iacc)
        iaddr_q <= imemaddr;
      if (dacc) begin
        dreq_q.wr   <= dmemWEN;
        dreq_q.addr <= dmemaddr;
        dreq_q.data <= dmemstore;
      end
      if (iacc || dacc)
        tcnt_q <= '0;
      else if (state == IREQ || state == DREQ)
        tcnt_q <= tcnt_q + 32'd1;
      if (ifill) begin
        tag_q   <= iaddr_q;
        bdata_q <= ramload;
        bvld_q  <= 1'b1;
      end else if (binval) begin
        bvld_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: RAM model with variable latency,
// vector table of single requests and hand-built corner sequences.
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] iq[$];
  logic [31:0] dq[$];

  dp_mem_responder #(
    .RAM_TIMEOUT(8),
    .IBUF_EN(1'b1)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .halt(halt),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .dmemREN(dmemREN),
    .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr),
    .dmemstore(dmemstore),
    .dhit(dhit),
    .dmemload(dmemload),
    .ramREN(ramREN),
    .ramWEN(ramWEN),
    .ramaddr(ramaddr),
    .ramstore(ramstore),
    .ramload(ramload),
    .ramstate(ramstate),
    .err(err)
  );

  always #5 CLK = ~CLK;

  // RAM model: unwritten words read as A0000000|addr.
  logic [31:0] mem [0:255];
  bit   [255:0] wvld;
  int   rcnt;
  int   lat = 3;
  bit   hold_busy = 1'b0;
  bit   inject_err = 1'b0;

  function automatic logic [31:0] word0(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) rcnt <= 0;
    else if ((ramREN || ramWEN) && ramstate != 2'd2)
      rcnt <= rcnt + 1;
    else rcnt <= 0;
  end

  always @(posedge CLK) begin
    if (ramWEN && ramstate == 2'd2) begin
      mem[ramaddr[9:2]]  <= ramstore;
      wvld[ramaddr[9:2]] <= 1'b1;
    end
  end

  always_comb begin
    ramstate = 2'd0;
    if (ramREN || ramWEN) begin
      if (inject_err) ramstate = 2'd3;
      else if (hold_busy || rcnt != lat) ramstate = 2'd1;
      else ramstate = 2'd2;
    end
  end

  assign ramload = (ramstate == 2'd2 && ramREN) ?
    (wvld[ramaddr[9:2]] ? mem[ramaddr[9:2]] : word0(ramaddr)) :
    32'h0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every hit pops an expected word.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit) begin
        if (iq.size() == 0) chk("ihit_unexpected", 32'd1, 32'd0);
        else chk("imemload", imemload, iq.pop_front());
      end else if (imemload != 0) begin
        chk("imemload_zero", imemload, 32'd0);
      end
      if (dhit) begin
        if (dq.size() == 0) chk("dhit_unexpected", 32'd1, 32'd0);
        else chk("dmemload", dmemload, dq.pop_front());
      end else if (dmemload != 0) begin
        chk("dmemload_zero", dmemload, 32'd0);
      end
    end
  end

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          strb;
  } vec_t;

  vec_t tbl[11];

  task automatic run_op(input vec_t v, input int idx);
    int cyc = 0;
    int strb = 0;
    bit got = 1'b0;
    if (v.kind == 0) begin
      iq.push_back(v.exp);
      imemREN  = 1'b1;
      imemaddr = v.addr;
    end else begin
      dq.push_back(v.exp);
      dmemaddr  = v.addr;
      dmemstore = v.wdata;
      dmemREN   = (v.kind == 1);
      dmemWEN   = (v.kind == 2);
    end
    while (!got && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (ramREN || ramWEN) strb++;
      got = (v.kind == 0) ? ihit : dhit;
    end
    chk($sformatf("row%0d_hit", idx), 32'(got), 32'd1);
    chk($sformatf("row%0d_strobes", idx), 32'(strb), 32'(v.strb));
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cyc, dcyc, icyc, strb, nih;
    logic gap;
    nRST = 1'b0; halt = 1'b0;
    imemREN = 1'b0; imemaddr = '0;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0;

    tbl[0]  = '{0, 32'h40,  0, 32'hA000_0040, 4};
    tbl[1]  = '{0, 32'h40,  0, 32'hA000_0040, 0};
    tbl[2]  = '{1, 32'h100, 0, 32'hA000_0100, 4};
    tbl[3]  = '{2, 32'h80,  32'h1234_5678, 32'h0, 4};
    tbl[4]  = '{1, 32'h80,  0, 32'h1234_5678, 4};
    tbl[5]  = '{0, 32'h40,  0, 32'hA000_0040, 0};
    tbl[6]  = '{2, 32'h40,  32'hDEAD_BEEF, 32'h0, 4};
    tbl[7]  = '{0, 32'h40,  0, 32'hDEAD_BEEF, 4};
    tbl[8]  = '{0, 32'h40,  0, 32'hDEAD_BEEF, 0};
    tbl[9]  = '{0, 32'h44,  0, 32'hA000_0044, 4};
    tbl[10] = '{0, 32'h40,  0, 32'hDEAD_BEEF, 4};

    #12;
    chk("rst0_ihit", 32'(ihit), 32'd0);
    chk("rst0_dhit", 32'(dhit), 32'd0);
    chk("rst0_strb", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst0_err", 32'(err), 32'd0);
    chk("rst0_imemload", imemload, 32'd0);
    chk("rst0_dmemload", dmemload, 32'd0);
    chk("rst0_ramaddr", ramaddr, 32'd0);
    chk("rst0_ramstore", ramstore, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 11; i++) run_op(tbl[i], i);

    // Data and fetch together: data first, one IDLE gap, then fetch.
    dq.push_back(32'hA000_0100);
    iq.push_back(32'hA000_0044);
    dmemREN = 1'b1; dmemaddr = 32'h100;
    imemREN = 1'b1; imemaddr = 32'h44;
    cyc = 0; dcyc = -10; icyc = -1; gap = 1'b1;
    while (icyc < 0 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (dhit) dcyc = cyc;
      if (ihit) icyc = cyc;
      if (cyc == dcyc + 1) gap = ramREN;
      @(posedge CLK);
      #1;
      if (cyc == dcyc) dmemREN = 1'b0;
    end
    imemREN = 1'b0;
    chk("prio_dhit_cyc", 32'(dcyc), 32'd5);
    chk("prio_ihit_cyc", 32'(icyc), 32'd10);
    chk("prio_gap_ramREN", 32'(gap), 32'd0);

    // Halt: buffered fetch suppressed, store still served.
    dq.push_back(32'h0);
    halt = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h44;
    dmemWEN = 1'b1; dmemaddr = 32'hC0;
    dmemstore = 32'h0000_55AA;
    strb = 0; nih = 0; dcyc = -10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (ramREN) strb++;
      if (ihit) nih++;
      if (dhit) dcyc = c;
      @(posedge CLK);
      #1;
      if (c == dcyc) dmemWEN = 1'b0;
    end
    chk("halt_ramREN", 32'(strb), 32'd0);
    chk("halt_ihit", 32'(nih), 32'd0);
    chk("halt_dhit_cyc", 32'(dcyc), 32'd5);
    iq.push_back(32'hA000_0044);
    halt = 1'b0;
    @(negedge CLK);
    chk("unhalt_ihit", 32'(ihit), 32'd1);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    chk("halt_store", wvld[8'h30] ? mem[8'h30] : 32'h0,
        32'h0000_55AA);

    // Buffer hit coinciding with IDLE taking a load.
    dq.push_back(32'hA000_0100);
    iq.push_back(32'hA000_0044);
    dmemREN = 1'b1; dmemaddr = 32'h100;
    imemREN = 1'b1; imemaddr = 32'h44;
    @(negedge CLK);
    chk("coin_ihit", 32'(ihit), 32'd1);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    cyc = 1; dcyc = -1;
    while (dcyc < 0 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (dhit) dcyc = cyc;
    end
    chk("coin_dhit_cyc", 32'(dcyc), 32'd5);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;

    // Timeout with RAM stuck BUSY.
    hold_busy = 1'b1;
    dmemREN = 1'b1; dmemaddr = 32'h100;
    cyc = 0; strb = 0;
    while (!err && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (ramREN) strb++;
    end
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy_cycles", 32'(strb), 32'd8);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    imemREN = 1'b1; imemaddr = 32'h44;
    strb = 0; nih = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (!err) nih++;
      if (ramREN || ramWEN || ihit || dhit) strb++;
    end
    chk("err_sticky", 32'(nih), 32'd0);
    chk("err_quiet", 32'(strb), 32'd0);
    hold_busy = 1'b0;
    do_reset();
    chk("rst_buf_invalid", 32'(ihit), 32'd0);
    imemREN = 1'b0;

    // Reset in the middle of a fetch.
    imemREN = 1'b1; imemaddr = 32'h48;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_ramREN", 32'(ramREN), 32'd1);
    #2;
    imemREN = 1'b0;
    do_reset();

    // RAM reports ERROR during a fetch.
    inject_err = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h48;
    cyc = 0; strb = 0;
    while (!err && cyc < 20) begin
      @(negedge CLK);
      cyc++;
      if (ramREN) strb++;
    end
    chk("ramerr_err", 32'(err), 32'd1);
    chk("ramerr_cycles", 32'(strb), 32'd1);
    imemREN = 1'b0;
    inject_err = 1'b0;
    do_reset();

    // Buffer was cleared by reset; RAM kept the store.
    run_op('{0, 32'h40, 0, 32'hDEAD_BEEF, 4}, 11);
    run_op('{0, 32'h40, 0, 32'hDEAD_BEEF, 0}, 12);

    repeat (2) @(negedge CLK);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
